// File: rtl/sseg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_if
//  Description : Bundles the scan tick, per-digit display data and the
//                registered anode/cathode drive of the seven-segment scanner.
//                master = the logic supplying digit data,
//                slave  = the scanner itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sseg_scan_if #(
    parameter int NDIGITS = 8
) ();
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    // Towards the scanner
    logic                   tick;
    logic [4*NDIGITS-1:0]   digits;
    logic [NDIGITS-1:0]     dp_in;
    logic [NDIGITS-1:0]     en_mask;

    // From the scanner
    logic [NDIGITS-1:0]     an;
    logic [6:0]             seg;
    logic                   dp;
    logic [IDX_W-1:0]       digit_idx;

    modport master (
        output tick, digits, dp_in, en_mask,
        input  an, seg, dp, digit_idx
    );

    modport slave (
        input  tick, digits, dp_in, en_mask,
        output an, seg, dp, digit_idx
    );
endinterface
`default_nettype wire

// File: rtl/sseg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan
//  Description : Time-multiplexed driver for an eight-digit common-anode
//                seven-segment display. Each rising edge of the slow scan
//                tick advances to the next digit; after every advance all
//                anodes are held off for BLANK_CYCLES clocks to suppress
//                ghosting. Hex nibbles are decoded to active-low segments.
//                All outputs are registered.
//  Options     : define SSEG_LZB_EN to enable leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan #(
    parameter int NDIGITS      = 8,
    parameter int BLANK_CYCLES = 16
) (
    input  wire        clk,
    input  wire        reset,
    sseg_scan_if.slave bus
);
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   digit_idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]   blank_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               tick_q;
    logic               step;
    logic [NDIGITS-1:0] dark;
    logic [NDIGITS-1:0] an_nxt;
    logic [3:0]         nibble_nxt;

    // Hex nibble to active-low {g,f,e,d,c,b,a}; lower-case b and d keep them
    // distinguishable from 8 and 0.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // The tick is produced by same-clock logic, so a single delay register
    // is enough for edge detection; a held-high tick yields one step.
    assign step = bus.tick & ~tick_q;

`ifdef SSEG_LZB_EN
    logic [NDIGITS-1:0] zero_tail;

    // zero_tail[i] is set when nibbles i..NDIGITS-1 are all zero.
    always_comb begin
        zero_tail = '0;
        zero_tail[NDIGITS-1] = (bus.digits[4*(NDIGITS-1) +: 4] == 4'h0);
        for (int i = NDIGITS - 2; i >= 0; i--) begin
            zero_tail[i] = zero_tail[i+1] & (bus.digits[4*i +: 4] == 4'h0);
        end
    end

    // Digits masked off, or leading zeros without a decimal point, stay dark;
    // digit 0 is exempt from blanking so a value of zero still shows "0".
    always_comb begin
        dark = ~bus.en_mask;
        for (int i = 1; i < NDIGITS; i++) begin
            if (zero_tail[i] && !bus.dp_in[i]) begin
                dark[i] = 1'b1;
            end
        end
    end
`else
    // Only the per-digit enable darkens a digit.
    always_comb begin
        dark = ~bus.en_mask;
    end
`endif

    // Scan sequencing: count out the blanking gap, then show the digit until
    // the next step. Steps arriving during the gap are ignored.
    always_comb begin
        state_nxt = state;
        idx_nxt   = digit_idx;
        cnt_nxt   = blank_cnt;
        case (state)
            ST_BLANK: begin
                if (blank_cnt == CNT_LAST) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = blank_cnt + 1'b1;
                end
            end
            ST_SHOW: begin
                if (step) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so anodes, segments and the
    // reported index all change together on the same edge.
    always_comb begin
        an_nxt = '1;
        if (state_nxt == ST_SHOW && !dark[idx_nxt]) begin
            an_nxt[idx_nxt] = 1'b0;
        end
        nibble_nxt = bus.digits[{idx_nxt, 2'b00} +: 4];
    end

    // State and registered display drive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_BLANK;
            digit_idx <= '0;
            blank_cnt <= '0;
            tick_q    <= 1'b0;
            bus.an    <= '1;
            bus.seg   <= 7'b1111111;
            bus.dp    <= 1'b1;
        end else begin
            state     <= state_nxt;
            digit_idx <= idx_nxt;
            blank_cnt <= cnt_nxt;
            tick_q    <= bus.tick;
            bus.an    <= an_nxt;
            bus.seg   <= hex_to_seg(nibble_nxt);
            bus.dp    <= ~bus.dp_in[idx_nxt];
        end
    end

    assign bus.digit_idx = digit_idx;

endmodule
`default_nettype wire

// File: doc/sseg_scan.md
# sseg_scan

Time-multiplexed driver for the Nexys4 eight-digit common-anode seven-segment display. Sits directly downstream of the clock divider: it consumes the divider's slow square-wave output (typically set for 1 kHz) as a scan tick. On each rising edge of that tick it advances to the next digit, and it inserts a short all-anodes-off gap between digits to suppress ghosting. It decodes 4-bit hex values to active-low segment patterns; all outputs are registered.

## Interface
Parameters:
- `NDIGITS`, 8: number of digits scanned (2..8).
- `BLANK_CYCLES`, 16: `clk` cycles during which all anodes are off after each digit advance. Must be ≥1.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  synchronous, active-low reset; sampled on `posedge clk`.
- `tick`  in  1  divider output, synchronous to `clk`; each rising edge is one scan step.
- `digits`  in  4*NDIGITS  hex value per digit; digit i = `digits[4*i+3:4*i]`.
- `dp_in`  in  NDIGITS  decimal point request per digit, 1 = lit.
- `en_mask`  in  NDIGITS  per-digit enable, 0 = digit forced dark.
- `an`  out  NDIGITS  anodes, active-low, one-hot-low or all ones.
- `seg`  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal-point cathode, active-low.
- `digit_idx`  out  $clog2(NDIGITS)  index of the digit currently selected.

## Operation
- Edge detect: `tick_q` is `tick` delayed by one register. A step occurs when `tick & ~tick_q`. There is no synchronizer; `tick` comes from same-clock logic.
- FSM states:
  - BLANK: `an` = all ones; `blank_cnt` increments each cycle. When `blank_cnt == BLANK_CYCLES-1`, go to SHOW and clear `blank_cnt`.
  - SHOW: `an[digit_idx]` = 0 if the digit is enabled, otherwise all ones. On a step, advance `digit_idx`, clear `blank_cnt`, and go to BLANK.
- Index advance: `digit_idx` increments by 1. At `NDIGITS-1` it wraps to 0.
- Steps that arrive while in BLANK are dropped. `digit_idx` does not change.
- Decode of the selected nibble to `seg`:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110
- `dp` = ~`dp_in[digit_idx]`.
- `seg` and `dp` track the selected digit in both states. Only `an` gates visibility.
- Reset values: state BLANK, `digit_idx` 0, `blank_cnt` 0, `tick_q` 0, `an` all ones, `seg` 1111111, `dp` 1.
- Reset mid-scan: outputs return to the reset values on the next edge; no step is carried over.

## Timing
- Step detected at edge E: `digit_idx` and state update at E, and `an` is all ones from E.
- `an` selects the new digit from edge E+BLANK_CYCLES.
- Changes on `digits`, `dp_in` or `en_mask` reach `seg`, `dp` and `an` one cycle later (registered).
- `tick` held high produces exactly one step. A `tick` high pulse of one cycle is sufficient.

## Configuration
- `SSEG_LZB_EN` defined (leading-zero blanking):
  - During SHOW, digit i>0 is dark (`an` all ones) when `digits` nibbles i..NDIGITS-1 are all 0 and `dp_in[i]` = 0.
  - Digit 0 is never blanked by this rule.
- `SSEG_LZB_EN` undefined: only `en_mask` darkens digits.

## Test plan
- Reset low for 3 cycles, then release with `tick`=0 → `an`=FF, `seg`=7F, `dp`=1. After 16 cycles, `an`=FE and `seg` shows `digits[3:0]`.
- `digits`=0x89ABCDEF, rising edge on `tick` every 200 cycles → `an` sequence FE,FD,…,7F,FE. `seg` sequence 0001110 (F), 0000110 (E), … 0000000 (8). Each digit is preceded by exactly 16 cycles of `an`=FF.
- Second `tick` edge issued 5 cycles after the first (inside BLANK) → `digit_idx` advances once only.
- `en_mask`=0xF0 → `an` stays FF while `digit_idx` is 0..3; the other digits display normally. `dp_in`=0x01 → `dp`=0 only when `digit_idx`=0.
- With `SSEG_LZB_EN`, `digits`=0x00000405 → digits 3..7 dark, digit 1 shows 0 (1000000), digits 0 and 2 lit. Without the macro, all 8 digits are lit.
- Reset asserted while `digit_idx`=5 in SHOW → next edge gives `an`=FF, `digit_idx`=0, `seg`=7F.
